// File: rtl/transpose_tile_unloader.sv
// Captures a parallel NUM_MG x NUM_PE tile and streams it out one element per
// transfer, in row- or column-major order, with a matching store byte address.
module transpose_tile_unloader #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned NUM_MG     = 16,
    parameter int unsigned NUM_PE     = NUM_MG,
    parameter int unsigned ADDR_WIDTH = 64
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         in_val,
    output logic                                         in_ready,
    input  logic [NUM_MG-1:0][NUM_PE-1:0][DATA_WIDTH-1:0] input_elements,
    input  logic                                         col_major,
    input  logic [ADDR_WIDTH-1:0]                        base_addr,
    output logic                                         out_val,
    input  logic                                         out_ready,
    output logic [DATA_WIDTH-1:0]                        output_e,
    output logic [ADDR_WIDTH-1:0]                        store_addr,
    output logic                                         done,
    output logic [1:0]                                   dbg_state
);

    localparam int unsigned NUM_EL = NUM_MG * NUM_PE;
    localparam int unsigned KW     = (NUM_EL > 1) ? $clog2(NUM_EL) : 1;
    localparam int unsigned MGW    = (NUM_MG > 1) ? $clog2(NUM_MG) : 1;
    localparam int unsigned PEW    = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam logic [KW-1:0]         K_LAST    = KW'(NUM_EL - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

    // Handshake: an element moves only on a clock edge where out_val and
    // out_ready are both 1; a tile is taken on an edge where in_ready and in_val are both 1.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                                        r_state;
    state_t                                        w_next;
    logic [NUM_MG-1:0][NUM_PE-1:0][DATA_WIDTH-1:0] r_tile;
    logic                                          r_col_major;
    logic [KW-1:0]                                 r_k;
    logic [ADDR_WIDTH-1:0]                         r_addr;
    logic                                          w_capture;
    logic                                          w_xfer;
    logic [MGW-1:0]                                w_row;
    logic [PEW-1:0]                                w_col;

    assign w_capture = (r_state == S_IDLE) && in_val;
    assign w_xfer    = (r_state == S_STREAM) && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_addr      <= '0;
            r_col_major <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_capture) begin
                r_col_major <= col_major;
                r_addr      <= base_addr;
                r_k         <= '0;
            end else if (w_xfer && (r_k != K_LAST)) begin
                // Address is tracked incrementally; it wraps naturally at 2^ADDR_WIDTH.
                r_k    <= r_k + KW'(1);
                r_addr <= r_addr + ADDR_STEP;
            end
        end
    end

    // Tile storage is pure datapath; the output is gated to zero outside STREAM.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_tile <= input_elements;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (in_val) w_next = S_STREAM;
            S_STREAM: if (w_xfer && (r_k == K_LAST)) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_row = '0;
        w_col = '0;
        if (r_col_major) begin
            w_row = MGW'(r_k % NUM_MG);
            w_col = PEW'(r_k / NUM_MG);
        end else begin
            w_row = MGW'(r_k / NUM_PE);
            w_col = PEW'(r_k % NUM_PE);
        end
    end

    assign in_ready   = (r_state == S_IDLE);
    assign out_val    = (r_state == S_STREAM);
    assign done       = (r_state == S_DONE);
    assign output_e   = (r_state == S_STREAM) ? r_tile[w_row][w_col] : '0;
    assign store_addr = (r_state == S_STREAM) ? r_addr : '0;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_transpose_tile_unloader.sv
// Directed bench for transpose_tile_unloader with a 4x4 tile of 16-bit elements
// where tile[i][j] = 16*i + j (plus an offset for the alternate tile).
module tb_transpose_tile_unloader;

    localparam int DW = 16;
    localparam int MG = 4;
    localparam int PE = 4;
    localparam int AW = 32;

    logic                             clk = 1'b0;
    logic                             rst = 1'b1;
    logic                             in_val = 1'b0;
    logic                             in_ready;
    logic [MG-1:0][PE-1:0][DW-1:0]    input_elements = '0;
    logic                             col_major = 1'b0;
    logic [AW-1:0]                    base_addr = '0;
    logic                             out_val;
    logic                             out_ready = 1'b0;
    logic [DW-1:0]                    output_e;
    logic [AW-1:0]                    store_addr;
    logic                             done;
    logic [1:0]                       dbg_state;

    int errors = 0;
    int checks = 0;

    int row_exp [16] = '{0, 1, 2, 3, 16, 17, 18, 19, 32, 33, 34, 35, 48, 49, 50, 51};
    int col_exp [16] = '{0, 16, 32, 48, 1, 17, 33, 49, 2, 18, 34, 50, 3, 19, 35, 51};

    transpose_tile_unloader #(
        .DATA_WIDTH(DW),
        .NUM_MG    (MG),
        .NUM_PE    (PE),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_val        (in_val),
        .in_ready      (in_ready),
        .input_elements(input_elements),
        .col_major     (col_major),
        .base_addr     (base_addr),
        .out_val       (out_val),
        .out_ready     (out_ready),
        .output_e      (output_e),
        .store_addr    (store_addr),
        .done          (done),
        .dbg_state     (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic fill_tile(input int offset);
        for (int i = 0; i < MG; i++)
            for (int j = 0; j < PE; j++)
                input_elements[i][j] = DW'(16 * i + j + offset);
    endtask

    // Called at a negedge while idle; returns at the negedge after the capture edge.
    task automatic capture_tile(input logic cm, input logic [AW-1:0] base, input int offset);
        fill_tile(offset);
        col_major = cm;
        base_addr = base;
        in_val    = 1'b1;
        @(negedge clk);
        in_val = 1'b0;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        in_val    = 1'b1;
        out_ready = 1'b1;
        fill_tile(0);
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, out_val, done} !== 3'b100) begin
            errors++;
            $display("FAIL reset_hold_ctrl got=%b exp=100", {in_ready, out_val, done});
        end
        rst    = 1'b0;
        in_val = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, out_val, done} !== 3'b100) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=100", {in_ready, out_val, done});
        end
        checks++;
        if (output_e !== 16'd0) begin
            errors++;
            $display("FAIL reset_output_e got=%0d exp=0", output_e);
        end
        checks++;
        if (store_addr !== 32'd0) begin
            errors++;
            $display("FAIL reset_store_addr got=%h exp=0", store_addr);
        end
        checks++;
        if (dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state got=%0d exp=0", dbg_state);
        end
        // out_ready high while idle must not start anything
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, out_val, done} !== 3'b100) begin
            errors++;
            $display("FAIL idle_ready_no_effect got=%b exp=100", {in_ready, out_val, done});
        end
    endtask

    task automatic test_row_major;
        out_ready = 1'b1;
        capture_tile(1'b0, 32'h0000_1000, 0);
        for (int k = 0; k < 16; k++) begin
            checks++;
            if ({out_val, output_e, store_addr} !== {1'b1, DW'(row_exp[k]), 32'h0000_1000 + AW'(2 * k)}) begin
                errors++;
                $display("FAIL row_major k=%0d got val=%b e=%0d a=%h exp val=1 e=%0d a=%h",
                         k, out_val, output_e, store_addr, row_exp[k], 32'h0000_1000 + AW'(2 * k));
            end
            @(negedge clk);
        end
        checks++;
        if ({done, out_val, in_ready} !== 3'b100) begin
            errors++;
            $display("FAIL row_done_pulse got=%b exp=100", {done, out_val, in_ready});
        end
        @(negedge clk);
        checks++;
        if ({done, out_val, in_ready} !== 3'b001) begin
            errors++;
            $display("FAIL row_back_idle got=%b exp=001", {done, out_val, in_ready});
        end
    endtask

    task automatic test_col_major;
        out_ready = 1'b1;
        capture_tile(1'b1, 32'h0000_1800, 0);
        for (int k = 0; k < 16; k++) begin
            checks++;
            if ({out_val, output_e, store_addr} !== {1'b1, DW'(col_exp[k]), 32'h0000_1800 + AW'(2 * k)}) begin
                errors++;
                $display("FAIL col_major k=%0d got val=%b e=%0d a=%h exp val=1 e=%0d a=%h",
                         k, out_val, output_e, store_addr, col_exp[k], 32'h0000_1800 + AW'(2 * k));
            end
            @(negedge clk);
        end
        checks++;
        if ({done, out_val, in_ready} !== 3'b100) begin
            errors++;
            $display("FAIL col_done_pulse got=%b exp=100", {done, out_val, in_ready});
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        out_ready = 1'b1;
        capture_tile(1'b0, 32'h0000_2000, 0);
        for (int k = 0; k < 16; k++) begin
            if (k == 6) begin
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    checks++;
                    if ({out_val, output_e, store_addr} !== {1'b1, 16'd18, 32'h0000_200C}) begin
                        errors++;
                        $display("FAIL stall_hold cyc=%0d got val=%b e=%0d a=%h exp val=1 e=18 a=0000200c",
                                 s, out_val, output_e, store_addr);
                    end
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
            checks++;
            if ({out_val, output_e, store_addr} !== {1'b1, DW'(row_exp[k]), 32'h0000_2000 + AW'(2 * k)}) begin
                errors++;
                $display("FAIL stall_stream k=%0d got e=%0d a=%h exp e=%0d a=%h",
                         k, output_e, store_addr, row_exp[k], 32'h0000_2000 + AW'(2 * k));
            end
            @(negedge clk);
        end
        checks++;
        if ({done, out_val, in_ready} !== 3'b100) begin
            errors++;
            $display("FAIL stall_done_pulse got=%b exp=100", {done, out_val, in_ready});
        end
        @(negedge clk);
    endtask

    task automatic test_busy_ignore;
        int ndone;
        out_ready = 1'b1;
        capture_tile(1'b0, 32'h0000_4000, 0);
        for (int k = 0; k < 16; k++) begin
            if (k == 3) begin
                fill_tile(256);
                col_major = 1'b1;
                base_addr = 32'h0000_5000;
                in_val    = 1'b1;
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_in_ready got=%b exp=0", in_ready);
                end
            end
            if (k == 5) in_val = 1'b0;
            checks++;
            if ({out_val, output_e, store_addr} !== {1'b1, DW'(row_exp[k]), 32'h0000_4000 + AW'(2 * k)}) begin
                errors++;
                $display("FAIL busy_stream k=%0d got e=%0d a=%h exp e=%0d a=%h",
                         k, output_e, store_addr, row_exp[k], 32'h0000_4000 + AW'(2 * k));
            end
            @(negedge clk);
        end
        ndone = 0;
        for (int c = 0; c < 4; c++) begin
            if (done === 1'b1) ndone++;
            @(negedge clk);
        end
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL busy_done_count got=%0d exp=1", ndone);
        end
    endtask

    task automatic test_reset_mid_stream;
        int ndone;
        out_ready = 1'b1;
        capture_tile(1'b0, 32'h0000_6000, 0);
        repeat (9) @(negedge clk);
        checks++;
        if (output_e !== 16'd33) begin
            errors++;
            $display("FAIL midrst_pre_k9 got=%0d exp=33", output_e);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({in_ready, out_val, done} !== 3'b100) begin
            errors++;
            $display("FAIL midrst_ctrl got=%b exp=100", {in_ready, out_val, done});
        end
        checks++;
        if ({output_e, store_addr} !== {16'd0, 32'd0}) begin
            errors++;
            $display("FAIL midrst_data got e=%0d a=%h exp e=0 a=0", output_e, store_addr);
        end
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            if (done === 1'b1) ndone++;
            @(negedge clk);
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL midrst_no_done got=%0d exp=0", ndone);
        end
        capture_tile(1'b1, 32'h0000_7000, 0);
        checks++;
        if ({out_val, output_e, store_addr} !== {1'b1, 16'd0, 32'h0000_7000}) begin
            errors++;
            $display("FAIL midrst_restart_k0 got val=%b e=%0d a=%h exp val=1 e=0 a=00007000",
                     out_val, output_e, store_addr);
        end
        @(negedge clk);
        checks++;
        if ({output_e, store_addr} !== {16'd16, 32'h0000_7002}) begin
            errors++;
            $display("FAIL midrst_restart_k1 got e=%0d a=%h exp e=16 a=00007002", output_e, store_addr);
        end
        repeat (16) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_drain_idle got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_addr_wrap;
        logic [AW-1:0] exp_addr;
        out_ready = 1'b1;
        capture_tile(1'b1, 32'hFFFF_FFFC, 0);
        for (int k = 0; k < 16; k++) begin
            exp_addr = 32'hFFFF_FFFC + AW'(2 * k);
            checks++;
            if ({output_e, store_addr} !== {DW'(col_exp[k]), exp_addr}) begin
                errors++;
                $display("FAIL addr_wrap k=%0d got e=%0d a=%h exp e=%0d a=%h",
                         k, output_e, store_addr, col_exp[k], exp_addr);
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL wrap_done got=%b exp=1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int first;
        int second;
        first  = -1;
        second = -1;
        fill_tile(0);
        col_major = 1'b0;
        base_addr = 32'h0000_8000;
        out_ready = 1'b1;
        in_val    = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (in_ready === 1'b1) begin
                if (first < 0) first = c;
                else second = c;
            end
            if (second >= 0) break;
            @(negedge clk);
        end
        @(negedge clk);
        in_val = 1'b0;
        checks++;
        if ((second - first) != 18) begin
            errors++;
            $display("FAIL b2b_spacing got=%0d exp=18", second - first);
        end
        repeat (20) @(negedge clk);
        checks++;
        if ({in_ready, out_val, done} !== 3'b100) begin
            errors++;
            $display("FAIL b2b_drain_idle got=%b exp=100", {in_ready, out_val, done});
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_row_major();
        test_col_major();
        test_backpressure();
        test_busy_ignore();
        test_reset_mid_stream();
        test_addr_wrap();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
